// File: rtl/clock_controller.sv
// SAP-style CPU clock controller: STOP/RUN/HALT sequencing, run-mode divider,
// single-step, T-state ring and executed-tick counter. All outputs registered.
module clock_controller #(
  parameter int DIV_W    = 24,
  parameter int T_STATES = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_pulse,
  input  logic                stop_pulse,
  input  logic                step_pulse,
  input  logic                clr_pulse,
  input  logic                hlt,
  input  logic [DIV_W-1:0]    div_load,
  output logic                cpu_ce,
  output logic [2:0]          t_state,
  output logic [T_STATES-1:0] ring,
  output logic                running,
  output logic                halted,
  output logic [CNT_W-1:0]    tick_count
);

  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div_cnt;

  state_t              w_nstate;
  logic                w_ce;
  logic                w_clr;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [2:0]          w_t_nxt;
  logic [CNT_W-1:0]    w_tick_nxt;
  logic [T_STATES-1:0] w_ring_nxt;

  // clr beats everything; then HALT is sticky; then hlt beats start/stop/step.
  always_comb begin
    w_nstate  = r_state;
    w_ce      = 1'b0;
    w_clr     = 1'b0;
    w_div_nxt = r_div_cnt;
    if (clr_pulse) begin
      w_clr     = 1'b1;
      w_div_nxt = '0;
      if (r_state == HALT) w_nstate = STOP;
    end else if (r_state == HALT) begin
      w_nstate = HALT;
    end else if (hlt) begin
      w_nstate = HALT;
    end else if (r_state == STOP) begin
      if (stop_pulse) begin
        w_nstate = STOP;
      end else if (start_pulse) begin
        w_nstate  = RUN;
        w_div_nxt = '0;
      end else if (step_pulse) begin
        w_ce = 1'b1;
      end
    end else begin
      if (stop_pulse) begin
        w_nstate = STOP;
      end else if (r_div_cnt == div_load) begin
        w_ce      = 1'b1;
        w_div_nxt = '0;
      end else begin
        // a div_load lowered below the count wraps through all-ones
        w_div_nxt = r_div_cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    w_t_nxt    = t_state;
    w_tick_nxt = tick_count;
    if (w_clr) begin
      w_t_nxt    = '0;
      w_tick_nxt = '0;
    end else if (w_ce) begin
      w_t_nxt    = (t_state == 3'(T_STATES-1)) ? 3'd0 : t_state + 3'd1;
      w_tick_nxt = tick_count + CNT_W'(1);
    end
    w_ring_nxt = {{(T_STATES-1){1'b0}}, 1'b1} << w_t_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= STOP;
      r_div_cnt  <= '0;
      cpu_ce     <= 1'b0;
      t_state    <= '0;
      ring       <= {{(T_STATES-1){1'b0}}, 1'b1};
      running    <= 1'b0;
      halted     <= 1'b0;
      tick_count <= '0;
    end else begin
      r_state    <= w_nstate;
      r_div_cnt  <= w_div_nxt;
      cpu_ce     <= w_ce;
      t_state    <= w_t_nxt;
      ring       <= w_ring_nxt;
      running    <= (w_nstate == RUN);
      halted     <= (w_nstate == HALT);
      tick_count <= w_tick_nxt;
    end
  end

endmodule

// File: tb/tb_clock_controller.sv
// Scoreboard bench: stimulus queues expected cpu_ce events (cycle, t_state,
// tick_count); a negedge monitor pops one per observed cpu_ce.
module tb_clock_controller;

  localparam int DIV_W = 24, T_STATES = 6, CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_pulse, stop_pulse, step_pulse, clr_pulse, hlt;
  logic [DIV_W-1:0]    div_load;
  logic                cpu_ce;
  logic [2:0]          t_state;
  logic [T_STATES-1:0] ring;
  logic                running, halted;
  logic [CNT_W-1:0]    tick_count;

  clock_controller #(.DIV_W(DIV_W), .T_STATES(T_STATES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .step_pulse(step_pulse), .clr_pulse(clr_pulse), .hlt(hlt), .div_load(div_load),
    .cpu_ce(cpu_ce), .t_state(t_state), .ring(ring), .running(running),
    .halted(halted), .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int t; int tick; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int mt = 0, mtick = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // expected state after the tick visible at negedge of cycle c
  task automatic exp_push(input int c);
    exp_t e;
    mtick = mtick + 1;
    mt    = (mt + 1) % T_STATES;
    e.c = c; e.t = mt; e.tick = mtick;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && cpu_ce) begin
      if (q.size() == 0) begin
        chk("unexpected_ce", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ce_cycle", cyc, e.c);
        chk("ce_t_state", int'(t_state), e.t);
        chk("ce_tick", int'(tick_count), e.tick);
        chk("ce_ring", int'(ring), 1 << e.t);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_stat(input string tag, input int run, input int hl, input int t, input int tk);
    chk({tag, "_running"}, int'(running), run);
    chk({tag, "_halted"}, int'(halted), hl);
    chk({tag, "_t_state"}, int'(t_state), t);
    chk({tag, "_ring"}, int'(ring), 1 << t);
    chk({tag, "_tick"}, int'(tick_count), tk);
  endtask

  int k;

  initial begin
    rst_n = 1'b0; start_pulse = 0; stop_pulse = 0; step_pulse = 0;
    clr_pulse = 0; hlt = 0; div_load = '0;
    idle(3);
    chk("rst_ce", int'(cpu_ce), 0);
    chk_stat("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_no_tick", int'(tick_count), 0);

    // three single steps, 4 cycles apart
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); step_pulse = 1; exp_push(cyc + 1);
      @(negedge clk); step_pulse = 0;
      idle(2);
    end
    idle(2);
    chk_stat("step", 0, 0, 3, 3);

    @(negedge clk); clr_pulse = 1; mt = 0; mtick = 0;
    @(negedge clk); clr_pulse = 0;
    chk_stat("clr_stop", 0, 0, 0, 0);

    // run with div_load=3: tick every 4th cycle, 6 ticks wrap t_state
    div_load = 3;
    @(negedge clk); k = cyc; start_pulse = 1;
    for (int i = 0; i < 6; i++) exp_push(k + 5 + 4*i);
    @(negedge clk); start_pulse = 0;
    chk("run_running", int'(running), 1);
    while (cyc < k + 26) @(negedge clk);
    stop_pulse = 1;
    @(negedge clk); stop_pulse = 0;
    idle(6);
    chk_stat("run6", 0, 0, 0, 6);

    // div_load=0: tick every cycle; clr in RUN stays RUN and skips one tick
    div_load = 0;
    @(negedge clk); k = cyc; start_pulse = 1; exp_push(k + 2); exp_push(k + 3);
    @(negedge clk); start_pulse = 0;
    @(negedge clk);
    @(negedge clk); clr_pulse = 1; mt = 0; mtick = 0; exp_push(k + 5);
    @(negedge clk); clr_pulse = 0;
    chk("clr_run_ce", int'(cpu_ce), 0);
    chk_stat("clr_run", 1, 0, 0, 0);
    @(negedge clk); hlt = 1;
    @(negedge clk);
    chk_stat("halt", 0, 1, 1, 1);
    hlt = 0; start_pulse = 1; step_pulse = 1;
    @(negedge clk); start_pulse = 0; step_pulse = 0;
    idle(5);
    chk_stat("halt_ign", 0, 1, 1, 1);

    @(negedge clk); clr_pulse = 1; mt = 0; mtick = 0;
    @(negedge clk); clr_pulse = 0;
    chk_stat("halt_clr", 0, 0, 0, 0);

    // start+stop together in STOP: stop wins
    @(negedge clk); start_pulse = 1; stop_pulse = 1;
    @(negedge clk); start_pulse = 0; stop_pulse = 0;
    idle(4);
    chk_stat("ss", 0, 0, 0, 0);

    // step in RUN must not disturb the cadence
    div_load = 3;
    @(negedge clk); k = cyc; start_pulse = 1;
    exp_push(k + 5); exp_push(k + 9); exp_push(k + 13);
    @(negedge clk); start_pulse = 0;
    while (cyc < k + 6) @(negedge clk);
    step_pulse = 1;
    @(negedge clk); step_pulse = 0;
    while (cyc < k + 14) @(negedge clk);
    stop_pulse = 1;
    @(negedge clk); stop_pulse = 0;
    idle(6);
    chk_stat("run_step", 0, 0, 3, 3);

    // async reset mid-period with div_load=7
    div_load = 7;
    @(negedge clk); k = cyc; start_pulse = 1; exp_push(k + 9);
    @(negedge clk); start_pulse = 0;
    while (cyc < k + 12) @(negedge clk);
    chk("pre_rst_running", int'(running), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ce", int'(cpu_ce), 0);
    chk_stat("arst", 0, 0, 0, 0);
    mt = 0; mtick = 0;
    @(negedge clk); rst_n = 1'b1;
    idle(20);
    chk_stat("post_rst", 0, 0, 0, 0);

    chk("pending_expected", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_controller.md
CLOCK_CONTROLLER -- requirements
Module: clock_controller

Interface
REQ-001 The block SHALL have parameter DIV_W, default 24, giving the width of the run-mode divider reload value.
REQ-002 The block SHALL have parameter T_STATES, default 6, giving the number of CPU T-states per instruction.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the executed-tick counter.
REQ-004 Port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start_pulse, input, 1 bit: one-clk pulse from a pulser; requests run mode.
REQ-007 Port stop_pulse, input, 1 bit: one-clk pulse; requests stop.
REQ-008 Port step_pulse, input, 1 bit: one-clk pulse; requests a single CPU tick.
REQ-009 Port clr_pulse, input, 1 bit: one-clk pulse; synchronous clear of T-state, tick counter and halt.
REQ-010 Port hlt, input, 1 bit: level HLT from the CPU control word.
REQ-011 Port div_load, input, DIV_W bits: run-mode period minus one, in clk cycles.
REQ-012 Port cpu_ce, output, 1 bit: registered one-clk CPU clock enable.
REQ-013 Port t_state, output, 3 bits: current T-state index, 0..T_STATES-1.
REQ-014 Port ring, output, T_STATES bits: one-hot decode of t_state.
REQ-015 Port running, output, 1 bit: high in state RUN.
REQ-016 Port halted, output, 1 bit: high in state HALT.
REQ-017 Port tick_count, output, CNT_W bits: number of cpu_ce pulses since the last clear.

Function
REQ-018 FSM states SHALL be STOP, RUN and HALT; all outputs SHALL be registered.
REQ-019 STOP -> RUN on start_pulse with stop_pulse=0 and hlt=0.
REQ-020 RUN -> STOP on stop_pulse.
REQ-021 Any state other than HALT -> HALT when hlt=1; hlt SHALL take priority over start, stop and step.
REQ-022 HALT SHALL be exited only by clr_pulse (-> STOP) or by reset; start, step and stop SHALL be ignored in HALT.
REQ-023 Simultaneous start_pulse and stop_pulse SHALL be resolved stop-wins.
REQ-024 In STOP, step_pulse with hlt=0 SHALL assert cpu_ce for exactly one cycle, on the cycle after the pulse.
REQ-025 step_pulse SHALL be ignored in RUN and HALT.
REQ-026 Run divider: div_cnt SHALL clear to 0 on entry to RUN and increment each cycle in RUN.
REQ-027 When div_cnt == div_load, cpu_ce SHALL be 1 on the next cycle and div_cnt SHALL wrap to 0.
REQ-028 div_load=0 SHALL produce cpu_ce on every cycle in RUN.
REQ-029 A div_load change SHALL take effect at the next compare; if div_cnt is already > div_load, div_cnt SHALL wrap at its all-ones value.
REQ-030 No cpu_ce SHALL be issued in the cycle following a cycle with hlt=1.
REQ-031 t_state SHALL advance by 1 on each issued cpu_ce and wrap from T_STATES-1 to 0.
REQ-032 ring SHALL equal 1 << t_state.
REQ-033 tick_count SHALL increment on each cpu_ce and wrap modulo 2^CNT_W.
REQ-034 clr_pulse SHALL, from any state, zero t_state, tick_count and div_cnt, move HALT to STOP, leave RUN in RUN, and suppress cpu_ce for the next cycle.
REQ-035 clr_pulse SHALL take priority over every other input except reset.

Reset
REQ-036 On rst_n=0, asynchronously: state=STOP, cpu_ce=0, t_state=0, ring=1, running=0, halted=0, tick_count=0, div_cnt=0.
REQ-037 After rst_n is released, no cpu_ce SHALL be issued until a start_pulse or step_pulse is received.

Verification
REQ-038 Reset, then three step_pulse inputs 4 cycles apart -> exactly three 1-cycle cpu_ce pulses, each 1 cycle after its step; t_state=3; tick_count=3.
REQ-039 div_load=3, start_pulse -> cpu_ce on every 4th cycle; after 6 pulses t_state=0 and ring=000001.
REQ-040 Running with div_load=0, assert hlt -> halted=1 next cycle; no further cpu_ce; start_pulse and step_pulse then have no effect.
REQ-041 In HALT, clr_pulse -> state STOP, t_state=0, tick_count=0, halted=0.
REQ-042 In STOP, start_pulse and stop_pulse in the same cycle -> remains STOP with no cpu_ce; in RUN, step_pulse has no effect on the cpu_ce cadence.
REQ-043 Running with div_load=7, rst_n pulsed low mid-period -> all outputs reach their reset values immediately and no cpu_ce is issued after release.
